// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) shared by both upstream masters and the downstream slave port.
// "master" is the side that issues addresses; "slave" is the side that returns data.
interface axi_rd_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 64
);
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [3:0]    arid;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic [3:0]    rid;
  logic          rlast;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rid, rlast
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rid, rlast
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave AXI4 read arbiter (m0 = IFU fetch, m1 = LSU load).
// One transaction at a time, round-robin on ties, grant held until the slave's rlast beat.
module axi_rd_arbiter #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic            clock,
  input  logic            reset,
  axi_rd_arbiter_if.slave  m0,
  axi_rd_arbiter_if.slave  m1,
  axi_rd_arbiter_if.master s
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          gnt, last_gnt;
  logic          s_arvalid_q;
  logic [AW-1:0] araddr_q;
  logic [3:0]    arid_q;
  logic [7:0]    arlen_q;
  logic [2:0]    arsize_q;
  logic [1:0]    arburst_q;

  logic          pick;
  logic          grant_fire;
  logic [DW-1:0] rdata_fan;

  // Tie goes to whoever did not win last time; a lone requester always wins.
  assign pick       = (m0.arvalid && m1.arvalid) ? ~last_gnt : m1.arvalid;
  assign grant_fire = (state == IDLE) && (m0.arvalid || m1.arvalid);

  always_comb begin
    // NOTE: every output and next-state gets a default first, so no path can infer a latch.
    state_nxt  = state;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m1.rvalid  = 1'b0;
    s.rready   = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_fire) begin
          state_nxt  = ADDR;
          m0.arready = ~reset & ~pick;
          m1.arready = ~reset & pick;
        end
      end
      ADDR: begin
        if (s_arvalid_q && s.arready) state_nxt = DATA;
      end
      DATA: begin
        m0.rvalid = s.rvalid & ~gnt;
        m1.rvalid = s.rvalid & gnt;
        s.rready  = gnt ? m1.rready : m0.rready;
        if (s.rvalid && s.rready && s.rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last_gnt    <= 1'b1;
      s_arvalid_q <= 1'b0;
      // NOTE: the latched AR fields are reset too, so s_ar* never shows X before the first grant.
      araddr_q    <= '0;
      arid_q      <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
    end else begin
      state <= state_nxt;
      if (grant_fire) begin
        gnt         <= pick;
        last_gnt    <= pick;
        s_arvalid_q <= 1'b1;
        araddr_q    <= pick ? m1.araddr  : m0.araddr;
        arid_q      <= pick ? m1.arid    : m0.arid;
        arlen_q     <= pick ? m1.arlen   : m0.arlen;
        arsize_q    <= pick ? m1.arsize  : m0.arsize;
        arburst_q   <= pick ? m1.arburst : m0.arburst;
      end else if (s_arvalid_q && s.arready) begin
        s_arvalid_q <= 1'b0;
      end
    end
  end

  assign s.arvalid = s_arvalid_q;
  assign s.araddr  = araddr_q;
  assign s.arid    = arid_q;
  assign s.arlen   = arlen_q;
  assign s.arsize  = arsize_q;
  assign s.arburst = arburst_q;

  // Response payload fans out to both masters; only rvalid is steered by the grant.
  assign rdata_fan = s.rdata;
  assign m0.rdata  = rdata_fan;
  assign m1.rdata  = rdata_fan;
  assign m0.rresp  = s.rresp;
  assign m1.rresp  = s.rresp;
  assign m0.rid    = s.rid;
  assign m1.rid    = s.rid;
  assign m0.rlast  = s.rlast;
  assign m1.rlast  = s.rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter: single fetch, tie-break, fairness, burst,
// slave/master stalls, error response forwarding and reset mid-burst.
module tb_axi_rd_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  axi_rd_arbiter_if #(.AW(32), .DW(64)) m0_bus ();
  axi_rd_arbiter_if #(.AW(32), .DW(64)) m1_bus ();
  axi_rd_arbiter_if #(.AW(32), .DW(64)) s_bus ();

  axi_rd_arbiter #(.AW(32), .DW(64)) dut (
    .clock (clock),
    .reset (reset),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later still.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    m0_bus.arvalid = 1'b0; m0_bus.araddr = '0; m0_bus.arid = '0; m0_bus.arlen = '0;
    m0_bus.arsize  = '0;   m0_bus.arburst = '0; m0_bus.rready = 1'b0;
    m1_bus.arvalid = 1'b0; m1_bus.araddr = '0; m1_bus.arid = '0; m1_bus.arlen = '0;
    m1_bus.arsize  = '0;   m1_bus.arburst = '0; m1_bus.rready = 1'b0;
    s_bus.arready  = 1'b0; s_bus.rvalid = 1'b0; s_bus.rdata = '0;
    s_bus.rresp    = '0;   s_bus.rid = '0;      s_bus.rlast = 1'b0;
  endtask

  initial begin
    clear_inputs();
    m0_bus.arvalid = 1'b1;  // request during reset must not be acknowledged
    tick();
    tick();
    settle();
    check("rst_m0_arready", m0_bus.arready, 1'b0);
    check("rst_s_arvalid",  s_bus.arvalid,  1'b0);
    check("rst_s_rready",   s_bus.rready,   1'b0);
    check("rst_s_araddr",   s_bus.araddr,   32'h0);
    m0_bus.arvalid = 1'b0;
    reset = 1'b0;
    tick();

    // ---- m0 alone, single beat ----
    m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h8000_0000; m0_bus.arid = 4'h1;
    m0_bus.arlen = 8'd0; m0_bus.arsize = 3'd3; m0_bus.arburst = 2'd1;
    s_bus.arready = 1'b1;
    settle();
    check("t1_m0_arready_grant", m0_bus.arready, 1'b1);
    check("t1_m1_arready_grant", m1_bus.arready, 1'b0);
    check("t1_s_arvalid_grant",  s_bus.arvalid,  1'b0);
    tick();
    m0_bus.arvalid = 1'b0;
    settle();
    check("t1_m0_arready_pulse", m0_bus.arready, 1'b0);
    check("t1_s_arvalid",        s_bus.arvalid,  1'b1);
    check("t1_s_araddr",         s_bus.araddr,   32'h8000_0000);
    check("t1_s_arid",           s_bus.arid,     4'h1);
    check("t1_s_arsize",         s_bus.arsize,   3'd3);
    check("t1_s_arburst",        s_bus.arburst,  2'd1);
    tick();
    settle();
    check("t1_s_arvalid_drop",   s_bus.arvalid,  1'b0);
    check("t1_m0_rvalid_wait",   m0_bus.rvalid,  1'b0);
    tick();
    s_bus.rvalid = 1'b1; s_bus.rdata = 64'h0000_0000_0010_0073; s_bus.rlast = 1'b1;
    s_bus.rid = 4'h1; m0_bus.rready = 1'b1;
    settle();
    check("t1_m0_rvalid", m0_bus.rvalid, 1'b1);
    check("t1_m0_rdata",  m0_bus.rdata,  64'h0000_0000_0010_0073);
    check("t1_m0_rid",    m0_bus.rid,    4'h1);
    check("t1_m1_rvalid", m1_bus.rvalid, 1'b0);
    check("t1_s_rready",  s_bus.rready,  1'b1);
    tick();
    settle();
    // Back in IDLE: a stray slave beat must be ignored.
    check("t1_idle_m0_rvalid", m0_bus.rvalid, 1'b0);
    check("t1_idle_s_rready",  s_bus.rready,  1'b0);
    clear_inputs();

    // ---- first tie after reset goes to m0, then m1 after one bubble ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h8000_0004;
    m1_bus.arvalid = 1'b1; m1_bus.araddr = 32'h8000_1000;
    s_bus.arready = 1'b1;
    settle();
    check("t2_m0_arready_tie", m0_bus.arready, 1'b1);
    check("t2_m1_arready_tie", m1_bus.arready, 1'b0);
    tick();
    m0_bus.arvalid = 1'b0;
    settle();
    check("t2_s_araddr_m0",    s_bus.araddr,   32'h8000_0004);
    check("t2_m1_arready_hold", m1_bus.arready, 1'b0);
    tick();
    s_bus.rvalid = 1'b1; s_bus.rlast = 1'b1; s_bus.rdata = 64'hA5A5; m0_bus.rready = 1'b1;
    settle();
    check("t2_m0_rvalid",       m0_bus.rvalid,  1'b1);
    check("t2_m1_rvalid",       m1_bus.rvalid,  1'b0);
    check("t2_m1_arready_data", m1_bus.arready, 1'b0);
    tick();
    s_bus.rvalid = 1'b0; m0_bus.rready = 1'b0;
    settle();
    check("t2_m1_arready_bubble", m1_bus.arready, 1'b1);
    tick();
    m1_bus.arvalid = 1'b0;
    settle();
    check("t2_s_arvalid_m1", s_bus.arvalid, 1'b1);
    check("t2_s_araddr_m1",  s_bus.araddr,  32'h8000_1000);
    tick();
    s_bus.rvalid = 1'b1; s_bus.rlast = 1'b1; s_bus.rdata = 64'h5A5A; m1_bus.rready = 1'b1;
    settle();
    check("t2_m1_rvalid", m1_bus.rvalid, 1'b1);
    check("t2_m0_rvalid", m0_bus.rvalid, 1'b0);
    check("t2_m1_rdata",  m1_bus.rdata,  64'h5A5A);

    // ---- fairness: m1 re-requests as it completes, m0 also requests -> m0 wins ----
    tick();
    s_bus.rvalid = 1'b0; m1_bus.rready = 1'b0;
    m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h8000_0008;
    m1_bus.arvalid = 1'b1; m1_bus.araddr = 32'h8000_2000; m1_bus.arlen = 8'd3;
    settle();
    check("t3_m0_arready_fair", m0_bus.arready, 1'b1);
    check("t3_m1_arready_fair", m1_bus.arready, 1'b0);
    tick();
    m0_bus.arvalid = 1'b0;
    settle();
    check("t3_s_araddr", s_bus.araddr, 32'h8000_0008);
    tick();
    s_bus.rvalid = 1'b1; s_bus.rlast = 1'b1; m0_bus.rready = 1'b1;
    tick();
    s_bus.rvalid = 1'b0; m0_bus.rready = 1'b0;

    // ---- m1 four-beat burst (arlen=3) ----
    settle();
    check("t4_m1_arready", m1_bus.arready, 1'b1);
    tick();
    m1_bus.arvalid = 1'b0;
    settle();
    check("t4_s_araddr", s_bus.araddr, 32'h8000_2000);
    check("t4_s_arlen",  s_bus.arlen,  8'd3);
    tick();
    m1_bus.rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_bus.rvalid = 1'b1; s_bus.rdata = 64'hB0 + 64'(i); s_bus.rlast = (i == 3);
      settle();
      check($sformatf("t4_beat%0d_rvalid", i), m1_bus.rvalid, 1'b1);
      check($sformatf("t4_beat%0d_rdata", i),  m1_bus.rdata,  64'hB0 + 64'(i));
      check($sformatf("t4_beat%0d_rlast", i),  m1_bus.rlast,  (i == 3));
      tick();
    end
    s_bus.rlast = 1'b0;  // rvalid still high: must be ignored in IDLE
    settle();
    check("t4_after_m1_rvalid", m1_bus.rvalid, 1'b0);
    check("t4_after_s_rready",  s_bus.rready,  1'b0);
    clear_inputs();

    // ---- address stall then master stall, SLVERR forwarded ----
    m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h8000_3000;
    tick();
    m0_bus.arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_bus.arready = (i == 3);
      settle();
      check($sformatf("t5_stall%0d_s_arvalid", i), s_bus.arvalid, 1'b1);
      check($sformatf("t5_stall%0d_s_araddr", i),  s_bus.araddr,  32'h8000_3000);
      tick();
    end
    s_bus.arready = 1'b0;
    s_bus.rvalid = 1'b1; s_bus.rlast = 1'b1; s_bus.rresp = 2'b10; s_bus.rdata = 64'hDEAD;
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("t5_rstall%0d_s_rready", i), s_bus.rready,  1'b0);
      check($sformatf("t5_rstall%0d_m0_rvalid", i), m0_bus.rvalid, 1'b1);
      tick();
    end
    m0_bus.rready = 1'b1;
    settle();
    check("t5_s_rready_rise", s_bus.rready,  1'b1);
    check("t5_m0_rresp",      m0_bus.rresp,  2'b10);
    check("t5_m1_rresp",      m1_bus.rresp,  2'b10);
    tick();
    settle();
    check("t5_done_m0_rvalid", m0_bus.rvalid, 1'b0);
    clear_inputs();

    // ---- reset during beat 2 of a 4-beat burst ----
    m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h8000_4000; m0_bus.arlen = 8'd3;
    s_bus.arready = 1'b1;
    tick();
    m0_bus.arvalid = 1'b0;
    tick();
    s_bus.rvalid = 1'b1; m0_bus.rready = 1'b1;
    tick();
    settle();
    check("t6_beat2_m0_rvalid", m0_bus.rvalid, 1'b1);
    reset = 1'b1;
    m0_bus.arvalid = 1'b1; m0_bus.araddr = 32'h8000_5000; m0_bus.arlen = 8'd0;
    tick();
    settle();
    check("t6_rst_s_rready",   s_bus.rready,   1'b0);
    check("t6_rst_s_arvalid",  s_bus.arvalid,  1'b0);
    check("t6_rst_m0_rvalid",  m0_bus.rvalid,  1'b0);
    check("t6_rst_m1_rvalid",  m1_bus.rvalid,  1'b0);
    check("t6_rst_m0_arready", m0_bus.arready, 1'b0);
    reset = 1'b0;
    s_bus.rvalid = 1'b0;
    m1_bus.arvalid = 1'b1; m1_bus.araddr = 32'h8000_6000;
    settle();
    check("t6_post_m0_arready", m0_bus.arready, 1'b1);
    check("t6_post_m1_arready", m1_bus.arready, 1'b0);
    tick();
    m0_bus.arvalid = 1'b0;
    settle();
    check("t6_post_s_araddr",  s_bus.araddr,  32'h8000_5000);
    check("t6_post_s_arvalid", s_bus.arvalid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
